// File: rtl/wisc_pkg.sv
// Shared types and constants for the 16-bit WISC pipeline.
// Holds the fetch FSM states, the IF/ID record and the ISA constants.
package wisc_pkg;

  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [3:0] HLT_OPCODE = 4'hF;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus2;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake plus the IF/ID outputs seen by Decode.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int PC_W = wisc_pkg::PC_W
);

  logic                         imem_req_o;
  logic [PC_W-1:0]              imem_addr_o;
  logic                         imem_rdy_i;
  logic [wisc_pkg::INSTR_W-1:0] imem_data_i;
  logic [wisc_pkg::INSTR_W-1:0] if_id_instr_o;
  logic [PC_W-1:0]              if_id_pc_plus2_o;
  logic                         if_id_valid_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rdy_i, imem_data_i,
    output if_id_instr_o, if_id_pc_plus2_o, if_id_valid_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rdy_i, imem_data_i,
    input  if_id_instr_o, if_id_pc_plus2_o, if_id_valid_o
  );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline stage register: payload plus valid, kill > load > hold.
// Latency 1 cycle; holding is simply load=0 and kill=0.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  // Kill only drops valid; the stale payload is harmless behind a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (kill) begin
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction fetch: owns the PC, requests imem, loads IF/ID one cycle after rdy.
// Stall parks a just-returned instruction in a one-entry skid buffer; flush beats everything.
module fetch_stage #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  fetch_stage_if.master     bus,
  output logic              halted_o
);

  import wisc_pkg::INSTR_W;
  import wisc_pkg::fetch_state_t;
  import wisc_pkg::FETCH;
  import wisc_pkg::HOLD;
  import wisc_pkg::HALT;

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(2);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus2;
  } fetch_pkt_t;

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_plus2;
  fetch_pkt_t      fetched, skid, skid_nxt, rf_d, rf_q;
  logic            rf_load, rf_kill, rf_vld;
  logic            fetched_hlt, skid_hlt;

  assign pc_plus2    = pc + PC_STEP;
  assign fetched     = '{instr: bus.imem_data_i, pc_plus2: pc_plus2};
  assign fetched_hlt = (bus.imem_data_i[INSTR_W-1 -: 4] == HLT_OPCODE);
  assign skid_hlt    = (skid.instr[INSTR_W-1 -: 4] == HLT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      skid  <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    skid_nxt  = skid;
    rf_load   = 1'b0;
    rf_kill   = 1'b0;
    rf_d      = fetched;

    if (flush_i) begin
      // Any outstanding request is abandoned; the skid contents become dead.
      pc_nxt    = redirect_pc_i & ALIGN_MASK;
      rf_kill   = 1'b1;
      state_nxt = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.imem_rdy_i) begin
            pc_nxt = pc_plus2;
            if (!stall_i) begin
              rf_load = 1'b1;
              if (fetched_hlt) state_nxt = HALT;
            end else begin
              skid_nxt  = fetched;
              state_nxt = HOLD;
            end
          end else if (!stall_i) begin
            rf_kill = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            rf_load   = 1'b1;
            rf_d      = skid;
            state_nxt = skid_hlt ? HALT : FETCH;
          end
        end
        HALT: begin
          if (!stall_i) rf_kill = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  if_id_reg #(.W($bits(fetch_pkt_t))) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (rf_load),
    .kill  (rf_kill),
    .d     (rf_d),
    .q     (rf_q),
    .vld   (rf_vld)
  );

  assign bus.imem_req_o       = (state == FETCH);
  assign bus.imem_addr_o      = pc;
  assign bus.if_id_instr_o    = rf_q.instr;
  assign bus.if_id_pc_plus2_o = rf_q.pc_plus2;
  assign bus.if_id_valid_o    = rf_vld;
  assign halted_o             = (state == HALT);

endmodule
